fft_input_loader: RTL
=====================

// Module: fft_input_loader
// PURPOSE
// Upstream of the DIT FFT core/AGU. Accepts one frame of N complex samples over a valid/ready stream.
// Writes the frame into the core's working bank at bit-reversed addresses, since DIT expects bit-reversed input.
// Then resets the core, pulses start, and blocks new input until the core reports done_fft.
// PARAMETERS
// MAX_N       1024               largest transform size; sizes the address space
// ADDR_WIDTH  $clog2(MAX_N)      memory address width
// DATA_WIDTH  32                 sample width, {re[31:16], im[15:0]}
// PORTS
// clk         in   1             clock
// reset       in   1             asynchronous, active-low reset
// N           in   ADDR_WIDTH+1  runtime transform size; legal values 4, 8, 16, 32
// in_valid    in   1             input sample valid
// in_ready    out  1             loader can accept a sample
// in_data     in   DATA_WIDTH    input sample
// in_last     in   1             marks the final sample of a frame
// mem_we      out  1             write enable to the working bank
// mem_addr    out  ADDR_WIDTH    bit-reversed write address
// mem_wdata   out  DATA_WIDTH    write data
// core_rst_n  out  1             active-low reset to the core/AGU
// fft_start   out  1             one-cycle start pulse to the core
// fft_done    in   1             done_fft level from the AGU
// frame_done  out  1             one-cycle pulse when the core finishes a frame
// err_n       out  1             level: N port illegal while IDLE
// err_len     out  1             one-cycle pulse: in_last mismatch
// BEHAVIOUR
// - Reset values: state=IDLE, count=0, mem_we=0, mem_addr=0, mem_wdata=0, core_rst_n=0, fft_start=0, frame_done=0, err_len=0.
// - After reset, core_rst_n goes to 1 on the first clk edge.
// - States:
//   - IDLE -> LOAD on the first handshake.
//   - LOAD -> CRST after sample N-1, or -> IDLE on an early in_last.
//   - CRST -> START -> WAIT.
//   - WAIT -> IDLE when fft_done=1.
// - Handshake: a transfer occurs when in_valid && in_ready. in_data must stay stable while valid && !ready.
// - in_ready (combinational):
//   - IDLE: high when N is legal.
//   - LOAD: always high.
//   - CRST, START, WAIT: low.
// - err_n = (state==IDLE) && N is illegal. Illegal N means no transfer is accepted.
// - On the IDLE handshake: latch n_lat=N and L=log2(N). That sample is sample 0. Later changes on N are ignored until the next IDLE.
// - Address: mem_addr = count bit-reversed over its low L bits; upper bits are 0.
// - Write latency: mem_we/mem_addr/mem_wdata are registered, one cycle after each handshake. mem_we is high exactly one cycle per accepted sample.
// - count increments per handshake and clears on leaving LOAD. No wrap inside a frame.
// - Final sample (count==n_lat-1) with in_last=0: pulse err_len, but the frame still proceeds to CRST.
// - in_last=1 with count<n_lat-1: that sample is written, err_len pulses, go to IDLE. No core reset and no start.
// - CRST: core_rst_n=0 for exactly one cycle; this clears the AGU's sticky done_fft. This cycle follows the last write cycle.
// - START: fft_start=1 for one cycle.
// - WAIT:
//   - fft_done is ignored in the first WAIT cycle.
//   - On fft_done=1: pulse frame_done and return to IDLE.
//   - A handshake is possible the next cycle.
// - fft_start and fft_done never coincide in a way that matters, since fft_done is sampled only in WAIT.
// - Reset asserted mid-operation:
//   - Immediate return to the reset values above.
//   - A partial frame is discarded.
//   - No start is issued.
// TESTING
// - N=8, samples 0..7 streamed back-to-back, in_last on 7 -> mem_addr 0,4,2,6,1,5,3,7, each one cycle after its handshake. Then one core_rst_n low cycle, then fft_start.
// - N=32, random in_valid gaps -> exactly 32 mem_we pulses; address for sample 1 = 16, sample 31 = 31, sample 6 = 12.
// - N=16, in_last on sample 9 -> 10 writes, err_len pulse, back to IDLE, no fft_start, in_ready high the next cycle.
// - N=12 in IDLE -> err_n=1, in_ready=0. Change N to 4 -> err_n=0, in_ready=1.
// - WAIT with fft_done held 0 for 50 cycles -> in_ready=0 throughout. Raise fft_done -> frame_done pulse, then IDLE.
// - Reset pulled low after 5 of 16 samples -> all outputs at reset values. The next frame restarts at address 0.

Source files
------------

// File: rtl/fft_input_loader_if.sv
// fft_input_loader_if: valid/ready sample stream into the FFT input loader
// master: sample source (drives in_valid/in_data/in_last, sees in_ready)
// slave:  loader (sees in_valid/in_data/in_last, drives in_ready)
interface fft_input_loader_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_last;
   modport master (output in_valid, in_data, in_last, input in_ready);
   modport slave  (input in_valid, in_data, in_last, output in_ready);
endinterface

// File: rtl/fft_input_loader.sv
// fft_input_loader: writes one frame bit-reversed into the FFT bank, then resets and starts the core
// clk, reset (async, active-low); N runtime size (4/8/16/32)
// s: sample stream (slave); mem_we/mem_addr/mem_wdata: working-bank write port
// core_rst_n/fft_start/fft_done: core control; frame_done/err_n/err_len: status
module fft_input_loader #(
   parameter int MAX_N      = 1024,
   parameter int ADDR_WIDTH = $clog2(MAX_N),
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH:0]   N,
   fft_input_loader_if.slave     s,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  core_rst_n,
   output logic                  fft_start,
   input  logic                  fft_done,
   output logic                  frame_done,
   output logic                  err_n,
   output logic                  err_len
);
   localparam int LW = $clog2(ADDR_WIDTH + 1);
   typedef enum logic [2:0] {IDLE, LOAD, CRST, START, WAIT} state_t;
   state_t                state, state_n;
   logic [ADDR_WIDTH-1:0] count, count_n, rev, addr_n;
   logic [ADDR_WIDTH:0]   n_lat, cur_n;
   logic [LW-1:0]         l_lat, n_l, cur_l;
   logic                  n_ok, hs, last_idx, done_seen;
   assign n_ok = N == (ADDR_WIDTH+1)'(4) || N == (ADDR_WIDTH+1)'(8) ||
                 N == (ADDR_WIDTH+1)'(16) || N == (ADDR_WIDTH+1)'(32);
   assign n_l = N[5] ? LW'(5) : N[4] ? LW'(4) : N[3] ? LW'(3) : LW'(2);
   assign s.in_ready = (state == IDLE && n_ok) || state == LOAD;
   assign err_n = state == IDLE && !n_ok;
   assign hs = s.in_valid && s.in_ready;
   // the IDLE handshake is sample 0 and must already use the live N
   assign cur_n = state == IDLE ? N : n_lat;
   assign cur_l = state == IDLE ? n_l : l_lat;
   assign last_idx = {1'b0, count} == cur_n - 1'b1;
   for (genvar i = 0; i < ADDR_WIDTH; i++) begin : g_rev
      assign rev[i] = count[ADDR_WIDTH-1-i];
   end
   // full-width reversal leaves the L-bit reversal in the top bits
   assign addr_n = rev >> (LW'(ADDR_WIDTH) - cur_l);
   // fft_start is high exactly in the first WAIT cycle, so it masks fft_done there
   assign done_seen = state == WAIT && fft_done && !fft_start;
   always_comb begin
      state_n = state;
      count_n = count;
      case (state)
         IDLE, LOAD: if (hs) begin
            if (last_idx) begin
               state_n = CRST;
               count_n = '0;
            end else if (s.in_last) begin
               state_n = IDLE;
               count_n = '0;
            end else begin
               state_n = LOAD;
               count_n = count + 1'b1;
            end
         end
         CRST:    state_n = START;
         START:   state_n = WAIT;
         WAIT:    state_n = done_seen ? IDLE : WAIT;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         count      <= '0;
         n_lat      <= '0;
         l_lat      <= '0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         core_rst_n <= 1'b0;
         fft_start  <= 1'b0;
         frame_done <= 1'b0;
         err_len    <= 1'b0;
      end else begin
         state      <= state_n;
         count      <= count_n;
         mem_we     <= hs;
         err_len    <= hs && (last_idx != s.in_last);
         core_rst_n <= state != CRST;
         fft_start  <= state == START;
         frame_done <= done_seen;
         if (hs && state == IDLE) begin
            n_lat <= N;
            l_lat <= n_l;
         end
         if (hs) begin
            mem_addr  <= addr_n;
            mem_wdata <= s.in_data;
         end
      end
   end
endmodule
